// File: rtl/approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_pipe
// Brief    : Signed adder with per-transaction exact/approximate mode, a
//            valid/ready pipeline and a saturating approximation-error counter.
// Revision : 1.0 - initial release
// ============================================================================
module approx_add_pipe #(
    parameter int WIDTH      = 16,
    parameter int APPROX_LSB = 3,
    parameter int STAGES     = 2,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_mode,
    output logic             out_err,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int              c_K       = APPROX_LSB;
    localparam int              c_HI_W    = WIDTH - APPROX_LSB + 1;
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    logic [WIDTH:0]  w_exact;
    logic [c_HI_W-1:0] w_hi;
    logic [WIDTH:0]  w_approx;
    logic [WIDTH:0]  w_sum;
    logic            w_err;
    logic            w_adv;

    logic             r_vld  [STAGES];
    logic [WIDTH:0]   r_sum  [STAGES];
    logic             r_mode [STAGES];
    logic             r_err  [STAGES];
    logic [ERR_W-1:0] r_err_cnt;

    // Whole result is formed before the first register; later stages only
    // delay it, so every boundary carries the final single-cycle value.
    always_comb begin
        w_exact  = {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};
        // Low bits copy B; A's top approximated bit stands in for the carry.
        w_hi     = {in_a[WIDTH-1], in_a[WIDTH-1:c_K]}
                 + {in_b[WIDTH-1], in_b[WIDTH-1:c_K]}
                 + c_HI_W'(in_a[c_K-1]);
        w_approx = {w_hi, in_b[c_K-1:0]};
        w_err    = in_mode & (w_approx != w_exact);
        w_sum    = in_mode ? w_approx : w_exact;
    end

    assign w_adv = ~r_vld[STAGES-1] | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i]  <= 1'b0;
                r_sum[i]  <= '0;
                r_mode[i] <= 1'b0;
                r_err[i]  <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0]  <= in_valid;
            r_sum[0]  <= w_sum;
            r_mode[0] <= in_mode;
            r_err[0]  <= w_err;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_sum[i]  <= r_sum[i-1];
                r_mode[i] <= r_mode[i-1];
                r_err[i]  <= r_err[i-1];
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (r_err_cnt != c_ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];
    assign out_sum   = r_sum[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];
    assign out_err   = r_err[STAGES-1];
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_approx_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_add_pipe
// Brief    : Bench for approx_add_pipe over a set of WIDTH/K/STAGES configs
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_add_pipe;

    localparam int c_NCFG = 19;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        in_mode;
    logic        out_ready;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config 0 is the default geometry (ERR_W=4); 1..18 sweep W x K x STAGES.
    function automatic int cfg_w(int g);
        if (g == 0) return 16;
        if ((g - 1) / 6 == 0) return 8;
        if ((g - 1) / 6 == 1) return 16;
        return 32;
    endfunction

    function automatic int cfg_k(int g);
        int ki;
        if (g == 0) return 3;
        ki = ((g - 1) / 2) % 3;
        if (ki == 0) return 1;
        if (ki == 1) return 3;
        return cfg_w(g) - 2;
    endfunction

    function automatic int cfg_s(int g);
        if (g == 0) return 2;
        return ((g - 1) % 2 == 0) ? 1 : 4;
    endfunction

    function automatic int cfg_e(int g);
        return (g == 0) ? 4 : 6;
    endfunction

    function automatic logic [65:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = v << (64 - w);
        t = t >>> (64 - w);
        return {{2{t[63]}}, t};
    endfunction

    // Reference: exact = A+B; approximate = floor(A/2^K)+floor(B/2^K)+A[K-1]
    // scaled back by 2^K with B's low K bits; both truncated to W+1 bits.
    function automatic logic [64:0] model_sum(input logic [63:0] a, input logic [63:0] b,
                                              input logic md, input int w, input int k);
        logic signed [65:0] ea, eb, ha, hb, c, low, r;
        logic [65:0] mask;
        ea = sx(a, w);
        eb = sx(b, w);
        if (!md) begin
            r = ea + eb;
        end else begin
            ha  = ea >>> k;
            hb  = eb >>> k;
            c   = {65'd0, a[k-1]};
            low = b & ((66'd1 << k) - 66'd1);
            r   = ha + hb + c;
            r   = (r <<< k) + low;
        end
        mask = (66'd1 << (w + 1)) - 66'd1;
        return 65'(r & mask);
    endfunction

    task automatic chk(input string nm, input int id, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d: got %0h want %0h", nm, id, act, exp);
        end
    endtask

    for (genvar g = 0; g < c_NCFG; g++) begin : g_cfg
        localparam int W  = cfg_w(g);
        localparam int K  = cfg_k(g);
        localparam int S  = cfg_s(g);
        localparam int EW = cfg_e(g);

        logic          in_ready, out_valid, out_mode, out_err;
        logic [W:0]    out_sum;
        logic [EW-1:0] err_cnt;

        logic          m_vld  [S];
        logic [64:0]   m_sum  [S];
        logic          m_mode [S];
        logic          m_err  [S];
        int            m_cnt;

        approx_add_pipe #(
            .WIDTH(W), .APPROX_LSB(K), .STAGES(S), .ERR_W(EW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready),
            .in_a(a64[W-1:0]), .in_b(b64[W-1:0]), .in_mode(in_mode),
            .out_valid(out_valid), .out_ready(out_ready),
            .out_sum(out_sum), .out_mode(out_mode), .out_err(out_err),
            .err_clr(err_clr), .err_cnt(err_cnt)
        );

        initial begin
            logic        adv;
            logic [64:0] ex, ap;
            m_cnt = 0;
            for (int i = 0; i < S; i++) begin
                m_vld[i] = 0; m_sum[i] = 0; m_mode[i] = 0; m_err[i] = 0;
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    m_cnt = 0;
                    for (int i = 0; i < S; i++) begin
                        m_vld[i] = 0; m_sum[i] = 0; m_mode[i] = 0; m_err[i] = 0;
                    end
                    chk("rst_sum", g, 65'(out_sum), 65'd0);
                    chk("rst_mode", g, 65'(out_mode), 65'd0);
                    chk("rst_err", g, 65'(out_err), 65'd0);
                end
                chk("in_ready", g, 65'(in_ready), 65'(!m_vld[S-1] || out_ready));
                chk("out_valid", g, 65'(out_valid), 65'(m_vld[S-1]));
                chk("err_cnt", g, 65'(err_cnt), 65'(m_cnt));
                if (m_vld[S-1]) begin
                    chk("out_sum", g, 65'(out_sum), m_sum[S-1]);
                    chk("out_mode", g, 65'(out_mode), 65'(m_mode[S-1]));
                    chk("out_err", g, 65'(out_err), 65'(m_err[S-1]));
                end
                if (rst_n) begin
                    adv = !m_vld[S-1] || out_ready;
                    if (err_clr) m_cnt = 0;
                    else if (m_vld[S-1] && out_ready && m_err[S-1] && m_cnt < (1 << EW) - 1)
                        m_cnt++;
                    if (adv) begin
                        for (int i = S - 1; i > 0; i--) begin
                            m_vld[i] = m_vld[i-1]; m_sum[i] = m_sum[i-1];
                            m_mode[i] = m_mode[i-1]; m_err[i] = m_err[i-1];
                        end
                        ex = model_sum(a64, b64, 1'b0, W, K);
                        ap = model_sum(a64, b64, 1'b1, W, K);
                        m_vld[0]  = in_valid;
                        m_sum[0]  = in_mode ? ap : ex;
                        m_mode[0] = in_mode;
                        m_err[0]  = in_mode && (ap != ex);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer on the default config, checked with literal results.
    task automatic send_check(input string nm, input logic [15:0] a, input logic [15:0] b,
                              input logic md, input logic [16:0] es, input logic ee);
        in_valid = 1; a64 = {48'd0, a}; b64 = {48'd0, b}; in_mode = md;
        step();
        in_valid = 0;
        chk({nm, "_lat1"}, 0, 65'(g_cfg[0].out_valid), 65'd0);
        step();
        chk({nm, "_vld"}, 0, 65'(g_cfg[0].out_valid), 65'd1);
        chk({nm, "_sum"}, 0, 65'(g_cfg[0].out_sum), 65'(es));
        chk({nm, "_err"}, 0, 65'(g_cfg[0].out_err), 65'(ee));
        step();
    endtask

    initial begin
        logic        acc, stalled_prev;
        logic [16:0] held;
        int          idx, got;

        rst_n = 0; in_valid = 0; a64 = 0; b64 = 0; in_mode = 0; out_ready = 1; err_clr = 0;
        repeat (3) step();
        chk("rst_valid", 0, 65'(g_cfg[0].out_valid), 65'd0);
        chk("rst_ready", 0, 65'(g_cfg[0].in_ready), 65'd1);
        chk("rst_cnt", 0, 65'(g_cfg[0].err_cnt), 65'd0);
        rst_n = 1;

        send_check("ap_4_3", 16'h0004, 16'h0003, 1'b1, 17'h0000B, 1'b1);
        send_check("ex_4_3", 16'h0004, 16'h0003, 1'b0, 17'h00007, 1'b0);
        send_check("ap_7fff_1", 16'h7FFF, 16'h0001, 1'b1, 17'h08001, 1'b1);
        send_check("ex_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b0);
        send_check("ex_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0);

        // Eight back-to-back exact transfers (sum = index+1), stalled on cycles 3..6.
        idx = 0; got = 0; held = 0; stalled_prev = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (idx < 8); a64 = 64'(idx + 1); b64 = 0; in_mode = 0;
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            acc = in_valid && g_cfg[0].in_ready;
            if (!out_ready && g_cfg[0].out_valid) begin
                chk("stall_ready", 0, 65'(g_cfg[0].in_ready), 65'd0);
                if (stalled_prev) chk("stall_stable", 0, 65'(g_cfg[0].out_sum), 65'(held));
            end
            stalled_prev = !out_ready && g_cfg[0].out_valid;
            held = g_cfg[0].out_sum;
            if (g_cfg[0].out_valid && out_ready) begin
                chk("stall_order", 0, 65'(g_cfg[0].out_sum), 65'(got + 1));
                got++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 0; out_ready = 1;
        chk("stall_count", 0, 65'(got), 65'd8);

        // Asynchronous reset with two transactions in flight.
        in_valid = 1; a64 = 5; b64 = 6; in_mode = 0;
        step();
        a64 = 7;
        step();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 0, 65'(g_cfg[0].out_valid), 65'd0);
        chk("arst_ready", 0, 65'(g_cfg[0].in_ready), 65'd1);
        step();
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("arst_no_stale", 0, 65'(g_cfg[0].out_valid), 65'd0);
            @(posedge clk); #1;
        end

        // Saturation of the 4-bit counter, then clear against a coincident error.
        err_clr = 1; step(); err_clr = 0;
        in_valid = 1; a64 = 4; b64 = 3; in_mode = 1; out_ready = 1;
        repeat (20) step();
        in_valid = 0;
        repeat (4) step();
        chk("sat_cnt", 0, 65'(g_cfg[0].err_cnt), 65'd15);
        in_valid = 1; step(); in_valid = 0; step();
        chk("clr_pre", 0, 65'(g_cfg[0].out_valid && g_cfg[0].out_err), 65'd1);
        err_clr = 1; step(); err_clr = 0;
        chk("clr_cnt", 0, 65'(g_cfg[0].err_cnt), 65'd0);

        // Randomised traffic across all configurations.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_mode   = $urandom % 2;
            err_clr   = ($urandom % 64) == 0;
            rst_n     = ($urandom % 400) != 0;
            case ($urandom % 8)
                0: begin a64 = '1; b64 = '1; end
                1: begin a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h0000_0000_0000_7FFF; end
                default: begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
            endcase
            step();
        end
        rst_n = 1; in_valid = 0; out_ready = 1; err_clr = 0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
